// File: rtl/pipe_pkg.sv
// pipe_pkg: stage state encoding and per-stage payload types with their NOP bubbles
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_t;

    typedef struct packed {
        logic        write_reg;
        logic        write_mem;
        logic        read_mem;
        logic [4:0]  rd;
        logic [63:0] alu_res;
        logic [63:0] store_data;
    } exme_t;

    localparam exme_t EXME_BUBBLE = '0;

    typedef struct packed {
        logic        write_reg;
        logic [4:0]  rd;
        logic [63:0] wb_data;
    } mewb_t;

    localparam mewb_t MEWB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready pipeline register with flush, optional skid entry and stall counter
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int            DW        = 128,
    parameter logic [DW-1:0] BUBBLE    = '0,
    parameter bit            REG_READY = 1'b1,
    parameter int            CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_t  state_q, state_d;
    logic [DW-1:0] main_q, main_d, skid_q;
    logic          fi, fo;

    assign out_valid = state_q != EMPTY;
    assign out_data  = main_q;
    assign fi        = in_valid && in_ready;
    assign fo        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: if (fi) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
                ONE: if (fi && !fo) begin
                    state_d = TWO;
                end else if (fi) begin
                    main_d  = in_data;
                end else if (fo) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
                TWO: if (fo) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= BUBBLE;
            stall_cnt <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            stall_cnt <= (out_valid && !out_ready && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
        end
    end

    // Skid entry holds the younger item while main waits; ready is registered from next state
    if (REG_READY) begin : g_skid
        logic rdy_q;
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                skid_q <= BUBBLE;
                rdy_q  <= 1'b1;
            end else begin
                skid_q <= (state_q == ONE && fi && !fo) ? in_data :
                          (state_q == TWO && fo)        ? BUBBLE  : skid_q;
                rdy_q  <= state_d != TWO;
            end
        end
        assign in_ready = rdy_q;
    end else begin : g_direct
        assign skid_q   = BUBBLE;
        assign in_ready = !out_valid || out_ready;
    end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: drives a registered-ready and a combinational-ready stage with identical stimulus, each checked by its own scoreboard
module tb_pipe_stage;

    localparam logic [7:0] BUB = 8'hEE;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic [1:0] ir, ov;
    logic [7:0] od [2];
    logic [3:0] cnt [2];

    logic [7:0] q [2][$];
    int         exp_cnt [2];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    pipe_stage #(.DW(8), .BUBBLE(BUB), .REG_READY(1'b1), .CNT_W(4)) u_reg (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .stall_cnt(cnt[0])
    );

    pipe_stage #(.DW(8), .BUBBLE(BUB), .REG_READY(1'b0), .CNT_W(4)) u_comb (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .stall_cnt(cnt[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, check against the models, then advance the models
    task automatic cyc(input logic r, input logic f, input logic iv, input logic [7:0] id, input logic ordy);
        logic [7:0] e;
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ovalid%0d", d), {7'd0, ov[d]}, {7'd0, q[d].size() != 0});
            chk($sformatf("iready%0d", d), {7'd0, ir[d]},
                {7'd0, d == 0 ? q[d].size() < 2 : (q[d].size() == 0 || ordy)});
            chk($sformatf("stall%0d", d), {4'd0, cnt[d]}, exp_cnt[d][7:0]);
            if (!ov[d]) chk($sformatf("bubble%0d", d), od[d], BUB);
            if (ov[d] && ordy && q[d].size() != 0) begin
                e = q[d].pop_front();
                chk($sformatf("data%0d", d), od[d], e);
            end
            if (r) begin
                q[d].delete();
                exp_cnt[d] = 0;
            end else begin
                if (ov[d] && !ordy && exp_cnt[d] != 15) exp_cnt[d]++;
                if (f) q[d].delete();
                else if (iv && ir[d]) q[d].push_back(id);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Reset with a live input that must never surface
        cyc(1, 0, 1, 8'hA5, 0);
        cyc(1, 0, 1, 8'hA5, 0);
        cyc(0, 0, 0, 8'h00, 1);
        // Streaming 1..8
        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 8'(i), 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        // Back-pressure: 1,2 accepted, 3 held upstream until ready
        cyc(0, 0, 1, 8'h01, 0);
        cyc(0, 0, 1, 8'h02, 0);
        cyc(0, 0, 1, 8'h03, 0);
        cyc(0, 0, 1, 8'h03, 0);
        cyc(0, 0, 1, 8'h03, 1);
        cyc(0, 0, 1, 8'h03, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 1);
        // Flush in TWO with a simultaneous output fire
        cyc(0, 0, 1, 8'h10, 0);
        cyc(0, 0, 1, 8'h11, 0);
        cyc(0, 1, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 1);
        // Input in the flush cycle is dropped; next cycle accepts
        cyc(0, 0, 1, 8'h20, 0);
        cyc(0, 1, 1, 8'h21, 1);
        cyc(0, 0, 1, 8'h22, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        // Stall counter saturation, survives flush, cleared by reset
        cyc(0, 0, 1, 8'h30, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 8'h00, 0);
        chk("sat0", {4'd0, cnt[0]}, 8'd15);
        cyc(0, 1, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        chk("flush_keeps_cnt", {4'd0, cnt[0]}, 8'd15);
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        chk("rst_clears_cnt", {4'd0, cnt[0]}, 8'd0);
        // Full stage with out_ready high: back-to-back transfers without a bubble
        cyc(0, 0, 1, 8'h40, 0);
        cyc(0, 0, 1, 8'h41, 1);
        cyc(0, 0, 1, 8'h42, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline stage register for the 5-stage RV64 core. It replaces the fixed-field, enable-gated stage registers with a generic valid/ready stage carrying a packed payload. The stage supports flush-to-bubble, optional skid buffering for full throughput with a registered `in_ready`, and a saturating back-pressure counter. Each core stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates one `pipe_stage` with its own payload width and bubble value.

## Interface
- `DW`, 128: payload width in bits (packed control + data fields of one stage).
- `BUBBLE`, `{DW{1'b0}}`: payload value presented when the stage is empty, reset or flushed. Stages encode their NOP control word here.
- `REG_READY`, 1: 1 selects a 2-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: stage can accept; transfer occurs when `in_valid && in_ready`.
- `in_data` in DW: upstream payload.
- `out_valid` out 1: downstream payload valid.
- `out_ready` in 1: downstream accepts; transfer occurs when `out_valid && out_ready`.
- `out_data` out DW: payload; equals `BUBBLE` whenever `out_valid=0`.
- `stall_cnt` out CNT_W: number of cycles with `out_valid && !out_ready`.

## Operation
- Registers:
  - `main` (DW): drives `out_data`.
  - `skid` (DW): present only when `REG_READY=1`.
  - state: EMPTY, ONE, TWO.
- Outputs by state:
  - `out_valid = (state != EMPTY)`.
  - `REG_READY=1`: `in_ready = (state != TWO)`, from a register.
  - `REG_READY=0`: `in_ready = !out_valid || out_ready`, combinational; TWO is unreachable.
- Transitions (fi = input fire, fo = output fire):
  - EMPTY, fi → ONE, `main<=in_data`.
  - ONE, fi&fo → ONE, `main<=in_data`.
  - ONE, fi only → TWO, `skid<=in_data`.
  - ONE, fo only → EMPTY, `main<=BUBBLE`.
  - ONE, neither → hold.
  - TWO, fo → ONE, `main<=skid`, `skid<=BUBBLE`.
  - TWO, no fo → hold (no fi is possible).
- Ordering is strict FIFO: `main` always holds the oldest entry.
- `flush`:
  - Next state EMPTY; `main` and `skid` <= BUBBLE.
  - Dominates any fi/fo in the same cycle; an input fired in the flush cycle is dropped, because upstream is flushed in the same cycle.
  - `stall_cnt` is unaffected.
- `rst`: same effect as `flush`, plus `stall_cnt<=0`. `rst` has priority over `flush`.
- `stall_cnt`:
  - Increments by 1 in each cycle with `out_valid && !out_ready && !rst`.
  - Saturates at 2^CNT_W−1; no wrap.
- Empty stage: no fi at EMPTY means `out_valid=0`, and `out_data=BUBBLE` on the following cycle.

## Timing
- Reset values, from the cycle after `rst` is sampled:
  - `out_valid=0`, `out_data=BUBBLE`, `in_ready=1`, `stall_cnt=0`, state EMPTY.
- Input presented during a `rst` cycle is discarded.
- Latency: `in_data` accepted at edge N appears on `out_data` after edge N; 1 cycle.
- Throughput: 1 transfer per cycle sustained in both modes while `out_ready=1`.
- `REG_READY=1`:
  - `in_ready` falls in the cycle after the fi that entered TWO.
  - `in_ready` rises in the cycle after the fo from TWO.
  - No combinational path from `out_ready` to `in_ready`.
- `REG_READY=0`: combinational path from `out_ready` to `in_ready`.
- Flush recovery: `out_valid=0` in the cycle after `flush`. A new entry may be accepted in that cycle.

## Structure
- Package `pipe_pkg`:
  - `stage_state_t` enum {EMPTY, ONE, TWO}.
  - Per-stage packed payload struct typedefs and their bubble constants, e.g. `EXME_BUBBLE` with writeReg/writeMem/readMem cleared.
- No sub-module needed. The skid path is a `generate` branch on `REG_READY`.
- Stage wrappers pack and unpack fields around one `pipe_stage` instance.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid=1`, `in_data=0xA5` → `out_valid=0`, `out_data=BUBBLE`, `in_ready=1`, `stall_cnt=0`; 0xA5 never appears.
- Streaming: `out_ready=1`, inputs 1..8 on consecutive cycles → outputs 1..8 on consecutive cycles, each 1 cycle late, `stall_cnt=0`.
- Back-pressure (`REG_READY=1`):
  - Stimulus: `out_ready=0` with inputs 1, 2, 3 offered.
  - Required: 1 and 2 accepted, `in_ready=0`, 3 held upstream.
  - Then `out_ready=1` → output order 1, 2, 3 with no loss or duplication.
  - `stall_cnt` equals the number of cycles `out_valid=1` with `out_ready=0`.
- Flush in TWO, with a simultaneous fo → next cycle `out_valid=0`, `out_data=BUBBLE`; neither held entry is ever emitted afterward.
- Saturation: `CNT_W=4`, hold a valid entry with `out_ready=0` for 20 cycles → `stall_cnt=15`; a following `flush` leaves it at 15; `rst` clears it to 0.
- `REG_READY=0`: full stage with `out_ready=1` → `in_ready=1` in the same cycle; back-to-back transfer with no bubble.
